bcd_convert_scheduler: RTL

BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

---
 rtl/bcd_convert_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/bcd_convert_scheduler.sv
// Two-requester binary-to-BCD converter: round-robin grant, then eight
// double-dabble iterations on the captured 8-bit operand.
module bcd_convert_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       done,
  output logic       owner,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] hundreds
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t     r_state;
  logic [7:0] r_shift;
  // Before the last shift the hundreds digit is at most 1, so one bit suffices.
  logic [8:0] r_scratch;
  logic [2:0] r_cnt;
  logic       r_cur;
  logic       r_last_owner;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic       r_busy;
  logic       r_done;
  logic       r_owner;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic [1:0] r_hundreds;

  logic       w_pick_b;
  logic [8:0] w_adj;
  logic [9:0] w_shifted;

  assign w_pick_b = req_b && (!req_a || !r_last_owner);

  assign w_adj[3:0] = (r_scratch[3:0] >= 4'd5) ? r_scratch[3:0] + 4'd3 : r_scratch[3:0];
  assign w_adj[7:4] = (r_scratch[7:4] >= 4'd5) ? r_scratch[7:4] + 4'd3 : r_scratch[7:4];
  assign w_adj[8]   = r_scratch[8];
  assign w_shifted  = {w_adj, r_shift[7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= 8'd0;
      r_scratch    <= 9'd0;
      r_cnt        <= 3'd0;
      r_cur        <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_owner      <= 1'b0;
      r_ones       <= 4'd0;
      r_tens       <= 4'd0;
      r_hundreds   <= 2'd0;
    end else begin
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_a || req_b) begin
            r_cur     <= w_pick_b;
            r_shift   <= w_pick_b ? data_b : data_a;
            r_scratch <= 9'd0;
            r_cnt     <= 3'd0;
            r_gnt_a   <= !w_pick_b;
            r_gnt_b   <= w_pick_b;
            r_busy    <= 1'b1;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_shift   <= {r_shift[6:0], 1'b0};
          r_scratch <= w_shifted[8:0];
          r_cnt     <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_ones       <= w_shifted[3:0];
            r_tens       <= w_shifted[7:4];
            r_hundreds   <= w_shifted[9:8];
            r_owner      <= r_cur;
            r_last_owner <= r_cur;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign owner    = r_owner;
  assign ones     = r_ones;
  assign tens     = r_tens;
  assign hundreds = r_hundreds;

endmodule
